// File: rtl/alu_op_issuer.sv
// ALU op issuer: decodes RV32 ALU/branch requests, drives an external ALU for one cycle, returns the result.
// Optional macro ALU_ISSUE_BACK_TO_BACK_EN lets RESP hand straight over to EXEC for 1 op / 2 cycles.
module alu_op_issuer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic        req_funct7_5,
  input  logic        req_is_branch,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_rs1_val,
  input  logic [31:0] req_rs2_val,
  output logic [2:0]  alu_opcode,
  output logic [31:0] alu_operand_1,
  output logic [31:0] alu_operand_2,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_taken,
  output logic        rsp_illegal,
  output logic [15:0] op_count
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_EQ   = 2'd1;
  localparam logic [1:0] BR_NE   = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic       illegal;
    logic [2:0] opcode;
    logic [1:0] br;
  } dec_t;

  function automatic dec_t decode(input logic [2:0] f3, input logic f7_5, input logic is_br);
    dec_t d;
    d.illegal = 1'b0;
    d.opcode  = OP_NOP;
    d.br      = BR_NONE;
    if (is_br) begin
      case (f3)
        3'b000:  begin d.opcode = OP_SUB; d.br = BR_EQ; end
        3'b001:  begin d.opcode = OP_SUB; d.br = BR_NE; end
        default: d.illegal = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000:  d.opcode = f7_5 ? OP_SUB : OP_ADD;
        3'b111:  d.opcode = OP_AND;
        3'b110:  d.opcode = OP_OR;
        3'b001:  d.opcode = OP_SLL;
        3'b101: begin
          if (!f7_5) begin
            d.opcode = OP_SRL;
          end else begin
            d.illegal = 1'b1;
          end
        end
        default: d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

  state_t      state_r;
  dec_t        dec_s;
  logic        req_fire_s;
  logic        rsp_fire_s;
  logic [2:0]  alu_opcode_r;
  logic        illegal_r;
  logic [1:0]  br_r;
  logic [4:0]  rd_r;
  logic [31:0] op1_r;
  logic [31:0] op2_r;
  logic [4:0]  rsp_rd_r;
  logic [31:0] rsp_data_r;
  logic        rsp_zero_r;
  logic        rsp_taken_r;
  logic        rsp_illegal_r;
  logic [15:0] op_count_r;

  // Request decode and handshake qualification.
  always_comb begin
    dec_s = decode(req_funct3, req_funct7_5, req_is_branch);
`ifdef ALU_ISSUE_BACK_TO_BACK_EN
    req_ready = (state_r == IDLE) || ((state_r == RESP) && rsp_ready);
`else
    req_ready = (state_r == IDLE);
`endif
    req_fire_s = req_valid && req_ready;
    rsp_fire_s = (state_r == RESP) && rsp_ready;
  end

  // FSM, operand/decode capture, response capture and op counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      alu_opcode_r  <= OP_NOP;
      illegal_r     <= 1'b0;
      br_r          <= BR_NONE;
      rd_r          <= 5'd0;
      op1_r         <= 32'd0;
      op2_r         <= 32'd0;
      rsp_rd_r      <= 5'd0;
      rsp_data_r    <= 32'd0;
      rsp_zero_r    <= 1'b0;
      rsp_taken_r   <= 1'b0;
      rsp_illegal_r <= 1'b0;
      op_count_r    <= 16'd0;
    end else begin
      // alu_opcode is only non-NOP during the single EXEC cycle that follows an accept.
      if (req_fire_s) begin
        alu_opcode_r <= dec_s.opcode;
        illegal_r    <= dec_s.illegal;
        br_r         <= dec_s.br;
        rd_r         <= req_rd;
        op1_r        <= req_rs1_val;
        op2_r        <= req_rs2_val;
      end else begin
        alu_opcode_r <= OP_NOP;
      end

      if (rsp_fire_s && (op_count_r != 16'hFFFF)) begin
        op_count_r <= op_count_r + 16'd1;
      end else begin
        op_count_r <= op_count_r;
      end

      case (state_r)
        IDLE: begin
          state_r <= req_fire_s ? EXEC : IDLE;
        end
        EXEC: begin
          state_r       <= RESP;
          rsp_rd_r      <= rd_r;
          rsp_illegal_r <= illegal_r;
          rsp_data_r    <= illegal_r ? 32'd0 : alu_result;
          rsp_zero_r    <= illegal_r ? 1'b1 : alu_zero;
          case (br_r)
            BR_EQ:   rsp_taken_r <= alu_zero;
            BR_NE:   rsp_taken_r <= ~alu_zero;
            default: rsp_taken_r <= 1'b0;
          endcase
        end
        RESP: begin
          if (rsp_fire_s) begin
            state_r <= req_fire_s ? EXEC : IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign alu_opcode    = alu_opcode_r;
  assign alu_operand_1 = op1_r;
  assign alu_operand_2 = op2_r;
  assign rsp_valid     = (state_r == RESP);
  assign rsp_rd        = rsp_rd_r;
  assign rsp_data      = rsp_data_r;
  assign rsp_zero      = rsp_zero_r;
  assign rsp_taken     = rsp_taken_r;
  assign rsp_illegal   = rsp_illegal_r;
  assign op_count      = op_count_r;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: directed vector table, corner sequences, random ops vs reference model.
module tb_alu_op_issuer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_funct7_5;
  logic        req_is_branch;
  logic [4:0]  req_rd;
  logic [31:0] req_rs1_val;
  logic [31:0] req_rs2_val;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_operand_1;
  logic [31:0] alu_operand_2;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_taken;
  logic        rsp_illegal;
  logic [15:0] op_count;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_count;

`ifdef ALU_ISSUE_BACK_TO_BACK_EN
  localparam int SPACING = 2;
`else
  localparam int SPACING = 3;
`endif

  typedef struct packed {
    logic [2:0]  f3;
    logic        f7;
    logic        br;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  stall;
    logic [2:0]  eop;
    logic [31:0] edata;
    logic        ez;
    logic        et;
    logic        ei;
  } vec_t;

  alu_op_issuer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_funct7_5(req_funct7_5), .req_is_branch(req_is_branch),
    .req_rd(req_rd), .req_rs1_val(req_rs1_val), .req_rs2_val(req_rs2_val),
    .alu_opcode(alu_opcode), .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU; NOP yields a non-zero garbage value so illegal-op forcing is observable.
  always_comb begin
    case (alu_opcode)
      3'b001:  alu_result = alu_operand_1 + alu_operand_2;
      3'b010:  alu_result = alu_operand_1 - alu_operand_2;
      3'b011:  alu_result = alu_operand_1 & alu_operand_2;
      3'b100:  alu_result = alu_operand_1 | alu_operand_2;
      3'b101:  alu_result = alu_operand_1 << alu_operand_2[4:0];
      3'b110:  alu_result = alu_operand_1 >> alu_operand_2[4:0];
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f3, input logic f7, input logic br, input logic [4:0] rd,
                              input logic [31:0] a, input logic [31:0] b, input logic [7:0] stall,
                              input logic [2:0] eop, input logic [31:0] edata,
                              input logic ez, input logic et, input logic ei);
    vec_t v;
    v.f3 = f3; v.f7 = f7; v.br = br; v.rd = rd; v.a = a; v.b = b; v.stall = stall;
    v.eop = eop; v.edata = edata; v.ez = ez; v.et = et; v.ei = ei;
    return v;
  endfunction

  // Reference model: RV32 semantics of the request, expressed directly as arithmetic.
  function automatic vec_t model(input logic [2:0] f3, input logic f7, input logic br, input logic [4:0] rd,
                                 input logic [31:0] a, input logic [31:0] b, input logic [7:0] stall);
    vec_t v;
    v = mk(f3, f7, br, rd, a, b, stall, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    if (br) begin
      if (f3 == 3'd0 || f3 == 3'd1) begin
        v.eop = 3'd2;
        v.edata = a - b;
        v.et = (f3 == 3'd0) ? (a == b) : (a != b);
      end else begin
        v.ei = 1'b1;
      end
    end else begin
      case (f3)
        3'd0: begin v.eop = f7 ? 3'd2 : 3'd1; v.edata = f7 ? a - b : a + b; end
        3'd7: begin v.eop = 3'd3; v.edata = a & b; end
        3'd6: begin v.eop = 3'd4; v.edata = a | b; end
        3'd1: begin v.eop = 3'd5; v.edata = a << b[4:0]; end
        3'd5: begin
          if (!f7) begin v.eop = 3'd6; v.edata = a >> b[4:0]; end
          else v.ei = 1'b1;
        end
        default: v.ei = 1'b1;
      endcase
    end
    if (v.ei) begin v.eop = 3'd0; v.edata = 32'd0; end
    v.ez = v.ei ? 1'b1 : (v.edata == 32'd0);
    return v;
  endfunction

  // One full transaction: accept, EXEC check, RESP check, optional backpressure, handshake.
  task automatic issue(input vec_t v);
    int n;
    logic acc;
    req_funct3 = v.f3; req_funct7_5 = v.f7; req_is_branch = v.br; req_rd = v.rd;
    req_rs1_val = v.a; req_rs2_val = v.b; req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0; acc = 1'b0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    chk("accept", {31'd0, acc}, 32'd1);
    if (acc) begin
      chk("exec_opcode", {29'd0, alu_opcode}, {29'd0, v.eop});
      chk("exec_operand_1", alu_operand_1, v.a);
      chk("exec_operand_2", alu_operand_2, v.b);
      chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("exec_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_data", rsp_data, v.edata);
      chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, v.ez});
      chk("rsp_taken", {31'd0, rsp_taken}, {31'd0, v.et});
      chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, v.ei});
      chk("rsp_rd", {27'd0, rsp_rd}, {27'd0, v.rd});
      chk("resp_opcode_nop", {29'd0, alu_opcode}, 32'd0);
      for (int i = 0; i < int'(v.stall); i++) begin
        @(posedge clk); #1;
        chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold_data", rsp_data, v.edata);
        chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("op_count", {16'd0, op_count}, {16'd0, exp_count});
    end
  endtask

  vec_t        vecs[12];
  vec_t        rv;
  logic [31:0] exp_q[$];
  int          t_resp[4];
  int          cyc, accepts, resps;
  logic        acc_now;
  logic [31:0] ra, rb;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_funct3 = 3'd0; req_funct7_5 = 1'b0; req_is_branch = 1'b0; req_rd = 5'd0;
    req_rs1_val = 32'd0; req_rs2_val = 32'd0;
    exp_count = 16'd0;

    vecs[0]  = mk(3'b000, 1'b0, 1'b0, 5'd1,  32'd5,          32'd7,        8'd0,  3'b001, 32'd12,         1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(3'b001, 1'b0, 1'b1, 5'd2,  32'h1234,       32'h1234,     8'd0,  3'b010, 32'd0,          1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(3'b000, 1'b0, 1'b1, 5'd3,  32'h1234,       32'h1234,     8'd1,  3'b010, 32'd0,          1'b1, 1'b1, 1'b0);
    vecs[3]  = mk(3'b101, 1'b1, 1'b0, 5'd4,  32'h80,         32'd2,        8'd0,  3'b000, 32'd0,          1'b1, 1'b0, 1'b1);
    vecs[4]  = mk(3'b001, 1'b0, 1'b0, 5'd5,  32'd1,          32'd4,        8'd10, 3'b101, 32'd16,         1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(3'b000, 1'b1, 1'b0, 5'd6,  32'd10,         32'd10,       8'd0,  3'b010, 32'd0,          1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(3'b111, 1'b0, 1'b0, 5'd7,  32'hF0F0,       32'hFF00,     8'd0,  3'b011, 32'hF000,       1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(3'b110, 1'b1, 1'b0, 5'd8,  32'hF0,         32'h0F,       8'd2,  3'b100, 32'hFF,         1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(3'b101, 1'b0, 1'b0, 5'd9,  32'h8000_0000,  32'd31,       8'd0,  3'b110, 32'd1,          1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(3'b010, 1'b0, 1'b0, 5'd10, 32'd3,          32'd9,        8'd0,  3'b000, 32'd0,          1'b1, 1'b0, 1'b1);
    vecs[10] = mk(3'b100, 1'b0, 1'b1, 5'd11, 32'd1,          32'd2,        8'd0,  3'b000, 32'd0,          1'b1, 1'b0, 1'b1);
    vecs[11] = mk(3'b001, 1'b0, 1'b1, 5'd31, 32'd3,          32'd4,        8'd3,  3'b010, 32'hFFFF_FFFF,  1'b0, 1'b1, 1'b0);

    // Reset with a request pending: it must not be taken.
    req_valid = 1'b1; req_rs1_val = 32'd5; req_rs2_val = 32'd7;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_alu_opcode", {29'd0, alu_opcode}, 32'd0);
    chk("rst_operand_1", alu_operand_1, 32'd0);
    chk("rst_operand_2", alu_operand_2, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rd", {27'd0, rsp_rd}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_flags", {29'd0, rsp_zero, rsp_taken, rsp_illegal}, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    rst = 1'b0; req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_accept_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_no_accept_op", {29'd0, alu_opcode}, 32'd0);
    end

    for (int i = 0; i < 12; i++) issue(vecs[i]);

    // Reset while the request is in EXEC: no response, count back to zero.
    req_funct3 = 3'b000; req_funct7_5 = 1'b0; req_is_branch = 1'b0; req_rd = 5'd12;
    req_rs1_val = 32'd40; req_rs2_val = 32'd2; req_valid = 1'b1;
    @(negedge clk);
    chk("pre_exec_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("exec_before_rst", {29'd0, alu_opcode}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1;
    exp_count = 16'd0;
    chk("rst_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_exec_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_exec_count", {16'd0, op_count}, 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    chk("rst_exec_count_after", {16'd0, op_count}, 32'd0);
    rsp_ready = 1'b0;

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? ra : $urandom;
      rv = model(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 31)), ra, rb, 8'($urandom_range(0, 3)));
      issue(rv);
    end

    // Throughput: continuous ADD stream with rsp_ready held high.
    req_funct3 = 3'b000; req_funct7_5 = 1'b0; req_is_branch = 1'b0; req_rd = 5'd9;
    req_rs1_val = 32'd100; req_rs2_val = 32'd1; req_valid = 1'b1; rsp_ready = 1'b1;
    cyc = 0; accepts = 0; resps = 0;
    while (resps < 4 && cyc < 60) begin
      @(negedge clk);
      acc_now = req_valid && req_ready;
      if (acc_now) begin
        exp_q.push_back(req_rs1_val + req_rs2_val);
        accepts++;
      end
      if (rsp_valid) begin
        t_resp[resps] = cyc;
        if (exp_q.size() > 0) chk("stream_data", rsp_data, exp_q.pop_front());
        else chk("stream_unexpected_rsp", 32'd1, 32'd0);
        resps++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_now) begin
        req_rs1_val = req_rs1_val + 32'd3;
        if (accepts == 4) req_valid = 1'b0;
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("stream_resps", resps, 32'd4);
    if (resps == 4) begin
      for (int i = 1; i < 4; i++) chk("stream_spacing", t_resp[i] - t_resp[i-1], SPACING);
    end
    exp_count = exp_count + 16'(resps);
    chk("stream_op_count", {16'd0, op_count}, {16'd0, exp_count});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
